// File: rtl/morph_filter.sv
// morph_filter: 3x3 grey-scale dilate / erode / pass filter over a raster pixel stream.
// Border rows and columns are dropped; each output lags its qualifying input by two cycles.
module morph_filter #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_mode,
    output logic              o_valid,
    output logic              o_sof,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ovf
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
    localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_DILATE = 2'b01;
    localparam logic [1:0] MODE_ERODE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [DATA_W-1:0] max_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] min_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [1:0]        mode_q, mode_d;
    logic              accept_s;
    logic [XW-1:0]     px_s;
    logic [YW-1:0]     py_s;
    logic              ovf_d;

    logic              v1_q, v1_d;
    logic              sof1_q, sof1_d;
    logic [1:0]        mode1_q;

    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];
    logic [DATA_W-1:0] win_q [3][3];

    logic [DATA_W-1:0] max_s, min_s, res_s;

    logic              o_valid_q, o_sof_q, o_ovf_q;
    logic [DATA_W-1:0] o_data_q;

    // Frame FSM, raster position of the current pixel and stage-1 qualifiers.
    always_comb begin
        accept_s = i_valid & (i_sof | (state_q == ST_RUN));
        px_s     = i_sof ? X_ZERO : x_q;
        py_s     = i_sof ? Y_ZERO : y_q;
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        mode_d   = mode_q;
        v1_d     = 1'b0;
        sof1_d   = 1'b0;
        ovf_d    = 1'b0;
        if (accept_s) begin
            if (i_sof) begin
                mode_d = i_mode;
            end else begin
                mode_d = mode_q;
            end
            v1_d   = (px_s >= X_TWO) && (py_s >= Y_TWO);
            sof1_d = (px_s == X_TWO) && (py_s == Y_TWO);
            if (px_s == X_LAST) begin
                x_d = X_ZERO;
                if (py_s == Y_LAST) begin
                    y_d     = Y_ZERO;
                    state_d = ST_DONE;
                end else begin
                    y_d     = py_s + Y_ONE;
                    state_d = ST_RUN;
                end
            end else begin
                x_d     = px_s + X_ONE;
                y_d     = py_s;
                state_d = ST_RUN;
            end
        end else begin
            // Only pixels arriving after a finished frame count as overrun.
            case (state_q)
                ST_DONE: ovf_d = i_valid;
                default: ovf_d = 1'b0;
            endcase
        end
    end

    // State, counters and latched frame mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= X_ZERO;
            y_q     <= Y_ZERO;
            mode_q  <= MODE_PASS;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
        end
    end

    // Line buffers and 3x3 window; row 0 of the window is the oldest line.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
            end
            win_q[0][2] <= lb2_q[px_s];
            win_q[1][2] <= lb1_q[px_s];
            win_q[2][2] <= i_data;
            lb2_q[px_s] <= lb1_q[px_s];
            lb1_q[px_s] <= i_data;
        end
    end

    // Window reduction selected by the mode carried with the pixel.
    always_comb begin
        max_s = win_q[0][0];
        min_s = win_q[0][0];
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                max_s = max_f(max_s, win_q[r][c]);
                min_s = min_f(min_s, win_q[r][c]);
            end
        end
        case (mode1_q)
            MODE_DILATE: res_s = max_s;
            MODE_ERODE:  res_s = min_s;
            default:     res_s = win_q[1][1];
        endcase
    end

    // Stage-1 qualifiers and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            sof1_q    <= 1'b0;
            mode1_q   <= MODE_PASS;
            o_valid_q <= 1'b0;
            o_sof_q   <= 1'b0;
            o_data_q  <= {DATA_W{1'b0}};
            o_ovf_q   <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            sof1_q    <= sof1_d;
            mode1_q   <= mode_d;
            o_valid_q <= v1_q;
            o_sof_q   <= v1_q & sof1_q;
            o_ovf_q   <= ovf_d;
            if (v1_q) begin
                o_data_q <= res_s;
            end else begin
                o_data_q <= o_data_q;
            end
        end
    end

    assign o_valid = o_valid_q;
    assign o_sof   = o_sof_q;
    assign o_data  = o_data_q;
    assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_morph_filter.sv
// Self-checking bench for morph_filter (8x6 image, 10-bit pixels): cycle-exact reference
// model of the output stream plus table-driven impulse frames and hand-written corner cases.
module tb_morph_filter;
    localparam int DW   = 10;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int N    = W * H;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_sof = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [1:0]    i_mode = 2'b00;
    logic          o_valid, o_sof, o_ovf;
    logic [DW-1:0] o_data;

    morph_filter #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
        .i_mode(i_mode), .o_valid(o_valid), .o_sof(o_sof), .o_data(o_data), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected outputs indexed by the clock edge after which they are visible.
    bit          exp_v [MAXC];
    bit          exp_s [MAXC];
    bit          exp_o [MAXC];
    bit          exp_r [MAXC];
    bit [DW-1:0] exp_d [MAXC];

    int          m_st = 0;      // 0 idle, 1 in frame, 2 frame finished
    int          m_pos = 0;
    logic [1:0]  m_mode = 2'b00;
    bit [DW-1:0] img [N];

    function automatic bit [DW-1:0] ref_pix(input int cx, input int cy, input logic [1:0] md);
        bit [DW-1:0] mx, mn, v;
        mx = '0;
        mn = '1;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                v = img[(cy + dy) * W + cx + dx];
                if (v > mx) mx = v;
                if (v < mn) mn = v;
            end
        end
        case (md)
            2'b01:   return mx;
            2'b10:   return mn;
            default: return img[cy * W + cx];
        endcase
    endfunction

    task automatic model(input bit r, input bit v, input bit s, input bit [DW-1:0] d,
                         input logic [1:0] m, input int n);
        int x, y;
        if (n + 1 >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d want<%0d", cyc, n, MAXC);
            $fatal(1);
        end
        if (r) begin
            m_st     = 0;
            m_pos    = 0;
            m_mode   = 2'b00;
            exp_v[n] = 1'b0;
            exp_o[n] = 1'b0;
            exp_r[n] = 1'b1;
        end else if (v && (s || m_st == 1)) begin
            if (s) begin
                m_pos  = 0;
                m_mode = m;
            end
            x = m_pos % W;
            y = m_pos / W;
            img[m_pos] = d;
            if (x >= 2 && y >= 2) begin
                exp_v[n+1] = 1'b1;
                exp_d[n+1] = ref_pix(x - 1, y - 1, m_mode);
                exp_s[n+1] = (x == 2 && y == 2);
            end
            m_pos++;
            m_st = (m_pos == N) ? 2 : 1;
        end else if (v && m_st == 2) begin
            exp_o[n] = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input bit [DW-1:0] d, input logic [1:0] m);
        @(negedge clk);
        #1;
        rst     = r;
        i_valid = v;
        i_sof   = s;
        i_data  = d;
        i_mode  = m;
        model(r, v, s, d, m, cyc + 1);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, '0, i_mode);
    endtask

    bit          mon_en = 1'b0;
    int          obs_v = 0, obs_h = 0, obs_s = 0, obs_o = 0;
    bit [DW-1:0] hit_val = '0;

    task automatic clr_obs();
        obs_v = 0; obs_h = 0; obs_s = 0; obs_o = 0;
    endtask

    // Cycle-by-cycle comparison against the reference model, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("o_valid", 32'(o_valid), 32'(exp_v[cyc]));
            chk("o_ovf", 32'(o_ovf), 32'(exp_o[cyc]));
            chk("o_sof", 32'(o_sof), (exp_v[cyc] ? 32'(exp_s[cyc]) : 32'd0));
            if (exp_v[cyc] && o_valid) chk("o_data", 32'(o_data), 32'(exp_d[cyc]));
            if (exp_r[cyc]) chk("rst_o_data", 32'(o_data), 32'd0);
            if (o_valid) obs_v++;
            if (o_valid && o_data == hit_val) obs_h++;
            if (o_sof) obs_s++;
            if (o_ovf) obs_o++;
        end
    end

    task automatic send_frame(input logic [1:0] md, input bit [DW-1:0] bg, input bit [DW-1:0] imp,
                              input int ix, input int iy, input bit gaps);
        for (int p = 0; p < N; p++) begin
            if (gaps) begin
                repeat ($urandom_range(2, 0)) step(1'b0, 1'b0, 1'b0, '0, md);
            end
            step(1'b0, 1'b1, (p == 0), ((p == iy * W + ix) ? imp : bg), md);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        bit [DW-1:0] bg;
        bit [DW-1:0] imp;
        int          ix;
        int          iy;
        bit          gaps;
        int          exp_hits;
    } scen_t;

    scen_t tbl [10];

    initial begin
        tbl[0] = '{2'b01, 10'h000, 10'h3FF, 4, 3, 1'b0, 9};
        tbl[1] = '{2'b10, 10'h3FF, 10'h000, 4, 3, 1'b0, 9};
        tbl[2] = '{2'b01, 10'h000, 10'h3FF, 4, 3, 1'b1, 9};
        tbl[3] = '{2'b00, 10'h000, 10'h3FF, 4, 3, 1'b0, 1};
        tbl[4] = '{2'b01, 10'h000, 10'h3FF, 0, 0, 1'b1, 1};
        tbl[5] = '{2'b10, 10'h3FF, 10'h000, 7, 5, 1'b0, 1};
        tbl[6] = '{2'b01, 10'h000, 10'h155, 1, 0, 1'b0, 2};
        tbl[7] = '{2'b11, 10'h000, 10'h3FF, 4, 3, 1'b1, 1};
        tbl[8] = '{2'b10, 10'h3FF, 10'h000, 6, 4, 1'b1, 4};
        tbl[9] = '{2'b01, 10'h000, 10'h200, 2, 2, 1'b0, 9};

        // Reset, then pixels without sof must be ignored.
        step(1'b1, 1'b1, 1'b0, 10'h3FF, 2'b01);
        mon_en = 1'b1;
        step(1'b1, 1'b1, 1'b0, 10'h3FF, 2'b01);
        clr_obs();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 10'($urandom), 2'b01);
        idle(3);
        chk("no_sof_outputs", obs_v, 0);
        chk("no_sof_ovf", obs_o, 0);

        // Reset asserted mid-frame while still streaming.
        for (int p = 0; p < 30; p++) step(1'b0, 1'b1, (p == 0), 10'($urandom), 2'b01);
        step(1'b1, 1'b1, 1'b0, 10'($urandom), 2'b01);
        step(1'b1, 1'b1, 1'b0, 10'($urandom), 2'b01);
        clr_obs();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 10'($urandom), 2'b01);
        idle(3);
        chk("post_rst_outputs", obs_v, 0);

        // Impulse frames from the table.
        for (int t = 0; t < 10; t++) begin
            clr_obs();
            hit_val = tbl[t].imp;
            send_frame(tbl[t].mode, tbl[t].bg, tbl[t].imp, tbl[t].ix, tbl[t].iy, tbl[t].gaps);
            idle(4);
            chk($sformatf("tbl%0d_count", t), obs_v, 24);
            chk($sformatf("tbl%0d_hits", t), obs_h, tbl[t].exp_hits);
            chk($sformatf("tbl%0d_sof", t), obs_s, 1);
        end

        // Mode toggled mid-frame, then a restart sof at (2,4).
        clr_obs();
        for (int p = 0; p < 34; p++)
            step(1'b0, 1'b1, (p == 0), 10'($urandom), ((p >= 27) ? 2'b10 : 2'b01));
        for (int p = 0; p < N; p++) step(1'b0, 1'b1, (p == 0), 10'($urandom), 2'b10);
        idle(4);
        chk("restart_count", obs_v, 36);
        chk("restart_sof", obs_s, 2);

        // Overrun after a complete frame, then normal resumption.
        clr_obs();
        send_frame(2'b01, 10'h000, 10'h3FF, 4, 3, 1'b0);
        step(1'b0, 1'b1, 1'b0, 10'h3FF, 2'b01);
        step(1'b0, 1'b1, 1'b0, 10'h3FF, 2'b01);
        idle(4);
        chk("ovf_count", obs_o, 2);
        chk("ovf_outputs", obs_v, 24);
        clr_obs();
        send_frame(2'b10, 10'h3FF, 10'h000, 4, 3, 1'b1);
        idle(4);
        chk("resume_count", obs_v, 24);
        chk("resume_ovf", obs_o, 0);

        // sof coinciding with what would be the last pixel of the frame.
        clr_obs();
        for (int p = 0; p < N - 1; p++) step(1'b0, 1'b1, (p == 0), 10'($urandom), 2'b01);
        for (int p = 0; p < N; p++) step(1'b0, 1'b1, (p == 0), 10'($urandom), 2'b10);
        idle(4);
        chk("sof_last_count", obs_v, 47);
        chk("sof_last_ovf", obs_o, 0);
        chk("sof_last_sof", obs_s, 2);
        step(1'b0, 1'b1, 1'b0, 10'h001, 2'b00);
        idle(3);
        chk("sof_last_done", obs_o, 1);

        // Random frames with random modes, gaps and mid-frame mode noise.
        for (int f = 0; f < 6; f++) begin
            logic [1:0] md;
            md = 2'($urandom_range(3, 0));
            for (int p = 0; p < N; p++) begin
                repeat ($urandom_range(1, 0)) step(1'b0, 1'b0, 1'b0, '0, 2'($urandom));
                step(1'b0, 1'b1, (p == 0), 10'($urandom), ((p == 0) ? md : 2'($urandom)));
            end
        end
        idle(4);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/morph_filter.md
MORPH_FILTER -- requirements
Module: morph_filter

Interface
REQ-001 Parameter DATA_W, default 10, pixel data width in bits.
REQ-002 Parameter IMG_W, default 640, active pixels per line (at least 3).
REQ-003 Parameter IMG_H, default 480, active lines per frame (at least 3).
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_valid  in  1  input pixel strobe; there is no backpressure.
REQ-007 i_sof  in  1  qualified by i_valid; marks pixel (0,0) of a frame.
REQ-008 i_data  in  DATA_W  input pixel, raster order.
REQ-009 i_mode  in  2  operation select: 00 pass, 01 dilate (max), 10 erode (min), 11 reserved (treated as pass).
REQ-010 o_valid  out  1  output pixel strobe.
REQ-011 o_sof  out  1  high with the first o_valid of each frame.
REQ-012 o_data  out  DATA_W  filtered pixel.
REQ-013 o_ovf  out  1  one-cycle pulse when a pixel is received beyond IMG_W*IMG_H without an intervening sof.

Function
REQ-014 Accepted pixel: i_valid=1 and the block is in state RUN, or i_valid=1 with i_sof=1 in any state.
REQ-015 States:
- IDLE: after reset; pixels without sof are ignored.
- RUN: frame in progress.
- DONE: frame complete; pixels without sof are ignored and pulse o_ovf.
REQ-016 Transitions:
- sof (any state) goes to RUN with column counter x=0 and row counter y=0 for that pixel.
- The last pixel (x=IMG_W-1, y=IMG_H-1) goes to DONE.
REQ-017 Counters advance per accepted pixel only. x wraps from IMG_W-1 to 0 and increments y at the wrap.
REQ-018 Two line buffers of IMG_W x DATA_W hold rows y-1 and y-2. A 3x3 window register shifts only on an accepted pixel; gaps in i_valid hold all state.
REQ-019 An accepted pixel at (x,y) with x>=2 and y>=2 SHALL produce exactly one output, centred at (x-1,y-1), over window rows y-2..y and columns x-2..x.
REQ-020 Output count per complete frame is (IMG_W-2)*(IMG_H-2). Border rows and columns are not emitted, and there is no wrap across line boundaries.
REQ-021 Latency: o_valid is asserted exactly 2 cycles after the qualifying input cycle. o_data, o_sof and o_valid are registered.
REQ-022 o_data SHALL be:
- dilate: unsigned maximum of the 9 window pixels.
- erode: unsigned minimum of the 9 window pixels.
- pass: the window centre pixel.
REQ-023 i_mode is latched on each sof and held for the whole frame; changes mid-frame have no effect until the next sof.
REQ-024 o_sof asserts with the output centred at (1,1) of each frame.
REQ-025 sof mid-frame aborts the current frame. Stale line-buffer data is never emitted, because rows 0..1 of the new frame produce no output (REQ-019). Outputs already in the 2-stage pipeline still complete.
REQ-026 sof on the same cycle as a pixel that would end the frame: sof wins, the pixel is (0,0) of the new frame, and there is no o_ovf.
REQ-027 o_ovf pulses one cycle after each ignored pixel received in DONE. It does not pulse for pixels ignored in IDLE.

Reset
REQ-028 While rst=1, the following SHALL hold, taking effect on the next edge:
- o_valid=0, o_sof=0, o_data=0, o_ovf=0.
- state=IDLE, x=0, y=0, latched mode=pass, pipeline valids cleared.
REQ-029 Line-buffer and window contents need not be cleared by reset.
REQ-030 Reset asserted mid-frame SHALL discard in-flight outputs: no o_valid the cycle after rst rises.

Verification (IMG_W=8, IMG_H=6, DATA_W=10)
REQ-031 Reset: rst=1 for 2 cycles while streaming pixels -> o_valid, o_sof, o_ovf and o_data all 0; inputs without sof after reset produce no output.
REQ-032 Dilate impulse: mode 01, all pixels 0 except 10'h3FF at (4,3), continuous valid -> 24 outputs:
- o_data=3FF at centres x=3..5, y=2..4 (9 outputs), 0 elsewhere.
- o_sof only on the first output.
- each output exactly 2 cycles after its input.
REQ-033 Erode impulse: mode 10, all 10'h3FF except 0 at (4,3) -> the same 9 centres are 0, the other 15 are 3FF.
REQ-034 Throttled input: REQ-032 stimulus with random i_valid gaps (about 50% duty) -> identical o_data sequence; every o_valid exactly 2 cycles after its qualifying input.
REQ-035 Mode and sof: i_mode toggled 01->10 at pixel (3,3) -> whole frame still dilated. A second sof at pixel (2,4) -> new frame restarts, and its first output has o_sof=1 at the new frame's (1,1).
REQ-036 Overrun: 48 pixels then 2 more without sof -> 2 o_ovf pulses, no o_valid; the next sof resumes normal output.
